divider_restoring_seq: RTL
==========================

// Module: divider_restoring_seq
// PURPOSE
//   Multicycle signed 32-bit restoring divider feeding the HI/LO muxes of the multicycle CPU datapath.
//   Takes dividend (A register) and divisor (B register) on a start pulse from the control unit.
//   Produces quotient (to LO) and remainder (to HI) plus done/zero-divisor flags that the control FSM waits on.
// PARAMETERS
//   WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//   clk        in   1      system clock, all state updates on rising edge
//   reset      in   1      synchronous, active-high reset
//   a_in       in   WIDTH  dividend, two's complement
//   b_in       in   WIDTH  divisor, two's complement
//   div_init   in   1      start pulse; sampled only in IDLE
//   div_busy   out  1      high from the edge after accepted start until div_stop drops
//   div_stop   out  1      one-cycle done pulse; hi_out/lo_out valid from this cycle on
//   div_zero   out  1      one-cycle pulse coincident with div_stop when divisor was 0
//   hi_out     out  WIDTH  remainder, sign follows dividend
//   lo_out     out  WIDTH  quotient, truncated toward zero
// BEHAVIOUR
//   Reset: state=IDLE; div_busy=0, div_stop=0, div_zero=0, hi_out=0, lo_out=0, iteration counter=0.
//   Reset wins over every other event, including mid-RUN; partial results discarded, hi/lo forced to 0.
//   States: IDLE -> RUN -> FIX -> DONE -> IDLE; IDLE -> DONE directly for zero divisor.
//   IDLE: on edge T with div_init=1: latch sign(a), sign(b); if b_in==0 -> DONE with div_zero armed;
//     else load |a_in| into quotient shift reg, |b_in| into divisor reg, clear partial remainder, cnt=0, -> RUN.
//   RUN: one restoring step per edge: {rem,q} <<= 1; trial = rem - div (WIDTH+1 bits);
//     if trial >= 0 then rem=trial, q[0]=1 else q[0]=0; cnt++; after WIDTH steps -> FIX.
//   FIX: lo_out = (sa^sb) ? -q : q; hi_out = sa ? -rem : rem; div_stop=1 registered; -> DONE.
//   DONE: div_stop (and div_zero if armed) high exactly this one cycle; -> IDLE next edge.
//   Latency: normal op: div_stop high in cycle after edge T+WIDTH+1 (34 cycles at WIDTH=32).
//     zero divisor: div_stop=div_zero=1 in cycle after edge T; hi_out/lo_out hold previous values.
//   Magnitudes computed in WIDTH-bit unsigned: |0x80000000| = 0x80000000 (no overflow trap).
//   0x80000000 / -1: lo_out=0x80000000, hi_out=0 (MIPS wrap); no flag raised.
//   div_init while div_busy=1 or in DONE: ignored, no restart, no queuing.
//   a_in/b_in only sampled at accepted start; later changes have no effect.
//   hi_out/lo_out change only at FIX edge or reset; stable at all other times.
//   div_init held high continuously: one operation per IDLE visit (restarts on the IDLE edge after DONE).
// CONFIGURATION
//   DIVIDER_RESTORING_DIVU_EN defined: extra input div_unsigned (1 bit), sampled with div_init;
//     when 1, operands treated as unsigned (no abs, no FIX negation) for DIVU; latency unchanged.
//   Not defined: port absent, always signed DIV semantics.
// TESTING
//   a=7, b=2, init -> after 34 cycles div_stop 1 cycle, lo=3, hi=1, div_zero=0.
//   a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
//   a=5, b=0 with prior lo=3, hi=1 -> next cycle div_stop=div_zero=1, lo=3, hi=1 unchanged.
//   a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; with DIVU_EN, div_unsigned=1 -> lo=0, hi=0x80000000.
//   start 100/7, pulse div_init again at cycle 10 -> ignored; single div_stop at 34, lo=14, hi=2.
//   start 100/7, assert reset at cycle 15 -> hi=lo=0, busy=0, no div_stop; new 9/3 then gives lo=3, hi=0.

Source files
------------

// File: rtl/divider_restoring_seq_if.sv
// ============================================================================
// Module : divider_restoring_seq_if
// Brief  : Operand/result bundle between the control unit and the divider.
//          DIVIDER_RESTORING_DIVU_EN adds the div_unsigned select.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface divider_restoring_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             div_init;
`ifdef DIVIDER_RESTORING_DIVU_EN
    logic             div_unsigned;
`endif
    logic             div_busy;
    logic             div_stop;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
`ifdef DIVIDER_RESTORING_DIVU_EN
        output div_unsigned,
`endif
        output a_in, b_in, div_init,
        input  div_busy, div_stop, div_zero, hi_out, lo_out
    );

    modport slave (
`ifdef DIVIDER_RESTORING_DIVU_EN
        input  div_unsigned,
`endif
        input  a_in, b_in, div_init,
        output div_busy, div_stop, div_zero, hi_out, lo_out
    );
endinterface

`default_nettype wire

// File: rtl/divider_restoring_seq.sv
// ============================================================================
// Module : divider_restoring_seq
// Brief  : Multicycle signed restoring divider (quotient -> LO, remainder -> HI).
//          Optional DIVIDER_RESTORING_DIVU_EN enables unsigned (DIVU) operation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module divider_restoring_seq #(
    parameter int WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    divider_restoring_seq_if.slave        bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sa_q;
    logic               sb_q;
    logic               busy_q;
    logic               stop_q;
    logic               zero_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               uns_d;
    logic               sa_d;
    logic               sb_d;
    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic [WIDTH:0]     shifted_d;
    logic [WIDTH:0]     trial_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   hi_d;

`ifdef DIVIDER_RESTORING_DIVU_EN
    assign uns_d = bus.div_unsigned;
`else
    assign uns_d = 1'b0;
`endif

    // Unsigned mode simply reports both operands as non-negative, so no abs or fix-up occurs
    assign sa_d    = ~uns_d & bus.a_in[WIDTH-1];
    assign sb_d    = ~uns_d & bus.b_in[WIDTH-1];
    assign abs_a_d = sa_d ? (~bus.a_in + 1'b1) : bus.a_in;
    assign abs_b_d = sb_d ? (~bus.b_in + 1'b1) : bus.b_in;

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial with its sign
    assign shifted_d = {rem_q, quo_q[WIDTH-1]};
    assign trial_d   = shifted_d - {1'b0, dvs_q};
    assign rem_d     = trial_d[WIDTH] ? shifted_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};

    assign lo_d = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
    assign hi_d = sa_q ? (~rem_q + 1'b1) : rem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            stop_q  <= 1'b0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.div_init) begin
                        sa_q   <= sa_d;
                        sb_q   <= sb_d;
                        busy_q <= 1'b1;
                        if (bus.b_in == '0) begin
                            stop_q  <= 1'b1;
                            zero_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            quo_q   <= abs_a_d;
                            dvs_q   <= abs_b_d;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo_q    <= lo_d;
                    hi_q    <= hi_d;
                    stop_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    stop_q  <= 1'b0;
                    zero_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.div_busy = busy_q;
    assign bus.div_stop = stop_q;
    assign bus.div_zero = zero_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

endmodule

`default_nettype wire
